// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: per-stage stall requests, EX multi-cycle control, shared-bus handshake, stall vector.
// Latency: none (signal container only).
// Backpressure: requesters hold req until the matching done pulse and drop it the following cycle.
interface pipe_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             stallreq_id;
    logic             ex_mc_start;
    logic [CNT_W-1:0] ex_mc_len;
    logic             ex_mc_busy;
    logic             if_req;
    logic             mem_req;
    logic             if_gnt;
    logic             mem_gnt;
    logic             bus_ack;
    logic             if_done;
    logic             mem_done;
    logic             bus_err;
    logic [5:0]       stall;

    // Controller side
    modport master (
        input  stallreq_id, ex_mc_start, ex_mc_len, if_req, mem_req, bus_ack,
        output ex_mc_busy, if_gnt, mem_gnt, if_done, mem_done, bus_err, stall
    );

    // Pipeline / bus side
    modport slave (
        output stallreq_id, ex_mc_start, ex_mc_len, if_req, mem_req, bus_ack,
        input  ex_mc_busy, if_gnt, mem_gnt, if_done, mem_done, bus_err, stall
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, runs EX multi-cycle countdown, arbitrates fetch/MEM on one bus.
// Latency: grants one cycle after req in IDLE; done/err/stall combinational in the finishing cycle.
// Backpressure: a transfer ends on bus_ack or after TIMEOUT bus cycles; one IDLE turnaround between transfers.
module pipe_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.master bus
);
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_IF   = 2'd1;
    localparam logic [1:0] ST_MEM  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  ex_cnt;
    logic              in_xfer;
    logic              timeout;
    logic              finish;
    logic              ex_go;
    logic [5:0]        stall_vec;

    // Transfer-end conditions; an ack in the timeout cycle still counts as a clean finish
    always_comb begin
        in_xfer = (state == ST_IF) || (state == ST_MEM);
        timeout = in_xfer && (wait_cnt == WAIT_LAST);
        finish  = in_xfer && (bus.bus_ack || timeout);
        ex_go   = bus.ex_mc_start && (bus.ex_mc_len != '0) && (ex_cnt == '0);
    end

    // Bus arbitration: MEM beats fetch from IDLE since it belongs to the older instruction
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.mem_req)
                    state_nxt = ST_MEM;
                else if (bus.if_req)
                    state_nxt = ST_IF;
            end
            ST_IF, ST_MEM: begin
                if (finish)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus state and per-transfer wait counter (restarts at 0 on every entry)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (in_xfer && !finish)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    // EX countdown: the start cycle itself is the first stall cycle, so load L-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ex_cnt <= '0;
        else if (ex_go)
            ex_cnt <= bus.ex_mc_len - 1'b1;
        else if (ex_cnt != '0)
            ex_cnt <= ex_cnt - 1'b1;
    end

    // Stall vector, highest stage wins; forced clear while reset is held
    always_comb begin
        stall_vec = 6'b000000;
        if (bus.mem_req && !bus.mem_done)
            stall_vec = 6'b011111;
        else if (ex_go || (ex_cnt != '0))
            stall_vec = 6'b001111;
        else if (bus.stallreq_id)
            stall_vec = 6'b000111;
        else if (bus.if_req && !bus.if_done)
            stall_vec = 6'b000011;
        if (!rst)
            stall_vec = 6'b000000;
    end

    assign bus.if_gnt     = (state == ST_IF);
    assign bus.mem_gnt    = (state == ST_MEM);
    assign bus.if_done    = (state == ST_IF)  && finish;
    assign bus.mem_done   = (state == ST_MEM) && finish;
    assign bus.bus_err    = timeout && !bus.bus_ack;
    assign bus.ex_mc_busy = (ex_cnt != '0);
    assign bus.stall      = stall_vec;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations plus randomized traffic.
// A cycle-indexed model (transfer owner/start cycle, last EX stall cycle) is compared every negedge.
// Requesters obey the hold-until-done / drop-next-cycle protocol using the model's done pulses.
module tb_pipe_ctrl;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 6;

    logic clk;
    logic rst;

    pipe_ctrl_if #(.CNT_W(CNT_W)) pif ();

    pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: who owns the bus (0 none, 1 fetch, 2 MEM), first bus cycle of the
    // transfer, and the last cycle index stalled by an EX multi-cycle op.
    int owner    = 0;
    int t0       = 0;
    int ex_until = -1;
    bit exp_if_done  = 1'b0;
    bit exp_mem_done = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // Reference model compare, once per cycle on the falling edge
    always @(negedge clk) begin
        bit tmo, fin, busy, ex_start, exp_err;
        int exp_stall;
        if (!rst) begin
            owner = 0; ex_until = -1;
            exp_if_done = 1'b0; exp_mem_done = 1'b0;
            chk("rst_stall",    int'(pif.stall),      0);
            chk("rst_if_gnt",   int'(pif.if_gnt),     0);
            chk("rst_mem_gnt",  int'(pif.mem_gnt),    0);
            chk("rst_busy",     int'(pif.ex_mc_busy), 0);
            chk("rst_if_done",  int'(pif.if_done),    0);
            chk("rst_mem_done", int'(pif.mem_done),   0);
            chk("rst_bus_err",  int'(pif.bus_err),    0);
        end else begin
            tmo          = (owner != 0) && (cyc - t0 == TIMEOUT - 1);
            fin          = (owner != 0) && (pif.bus_ack || tmo);
            exp_if_done  = (owner == 1) && fin;
            exp_mem_done = (owner == 2) && fin;
            exp_err      = tmo && !pif.bus_ack;
            busy         = (cyc <= ex_until);
            ex_start     = pif.ex_mc_start && (pif.ex_mc_len != 0) && !busy;
            if (pif.mem_req && !exp_mem_done)      exp_stall = 31;
            else if (ex_start || busy)             exp_stall = 15;
            else if (pif.stallreq_id)              exp_stall = 7;
            else if (pif.if_req && !exp_if_done)   exp_stall = 3;
            else                                   exp_stall = 0;

            chk("if_gnt",   int'(pif.if_gnt),     int'(owner == 1));
            chk("mem_gnt",  int'(pif.mem_gnt),    int'(owner == 2));
            chk("if_done",  int'(pif.if_done),    int'(exp_if_done));
            chk("mem_done", int'(pif.mem_done),   int'(exp_mem_done));
            chk("bus_err",  int'(pif.bus_err),    int'(exp_err));
            chk("ex_busy",  int'(pif.ex_mc_busy), int'(busy));
            chk("stall",    int'(pif.stall),      exp_stall);

            if (fin) begin
                owner = 0;
            end else if (owner == 0) begin
                if (pif.mem_req) begin owner = 2; t0 = cyc + 1; end
                else if (pif.if_req) begin owner = 1; t0 = cyc + 1; end
            end
            if (ex_start)
                ex_until = cyc + int'(pif.ex_mc_len) - 1;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pif.stallreq_id = 1'b0;
        pif.ex_mc_start = 1'b0;
        pif.ex_mc_len   = '0;
        pif.if_req      = 1'b0;
        pif.mem_req     = 1'b0;
        pif.bus_ack     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            clear_inputs();
        end
    endtask

    // Requester behaviour: drop the cycle after done, optionally raise a new request
    task automatic drive_reqs(input bit allow_new);
        if (pif.mem_req) begin
            if (exp_mem_done) pif.mem_req = 1'b0;
        end else if (allow_new && $urandom_range(0, 3) == 0) begin
            pif.mem_req = 1'b1;
        end
        if (pif.if_req) begin
            if (exp_if_done) pif.if_req = 1'b0;
        end else if (allow_new && $urandom_range(0, 2) == 0) begin
            pif.if_req = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

        // Fetch: req at c0, ack at c3
        tick(); pif.if_req = 1'b1; #1;
        chk("fetch_c0_stall", int'(pif.stall), 3);
        chk("fetch_c0_gnt",   int'(pif.if_gnt), 0);
        for (int k = 1; k <= 2; k++) begin
            tick(); #1;
            chk("fetch_gnt",   int'(pif.if_gnt), 1);
            chk("fetch_done0", int'(pif.if_done), 0);
            chk("fetch_stall", int'(pif.stall), 3);
        end
        tick(); pif.bus_ack = 1'b1; #1;
        chk("fetch_c3_gnt",   int'(pif.if_gnt), 1);
        chk("fetch_c3_done",  int'(pif.if_done), 1);
        chk("fetch_c3_stall", int'(pif.stall), 0);
        tick(); clear_inputs(); #1;
        chk("fetch_c4_gnt", int'(pif.if_gnt), 0);
        idle(2);

        // Contention: MEM wins, then one IDLE cycle, then fetch
        tick(); pif.if_req = 1'b1; pif.mem_req = 1'b1; #1;
        chk("cont_c0_stall", int'(pif.stall), 31);
        tick(); pif.bus_ack = 1'b1; #1;
        chk("cont_c1_mgnt",  int'(pif.mem_gnt), 1);
        chk("cont_c1_ignt",  int'(pif.if_gnt), 0);
        chk("cont_c1_mdone", int'(pif.mem_done), 1);
        chk("cont_c1_stall", int'(pif.stall), 3);
        tick(); pif.mem_req = 1'b0; pif.bus_ack = 1'b0; #1;
        chk("cont_c2_mgnt", int'(pif.mem_gnt), 0);
        chk("cont_c2_ignt", int'(pif.if_gnt), 0);
        tick(); pif.bus_ack = 1'b1; #1;
        chk("cont_c3_ignt",  int'(pif.if_gnt), 1);
        chk("cont_c3_idone", int'(pif.if_done), 1);
        idle(2);

        // EX countdown len=5, second start ignored
        tick(); pif.ex_mc_start = 1'b1; pif.ex_mc_len = 6'd5; #1;
        chk("ex_c0_stall", int'(pif.stall), 15);
        chk("ex_c0_busy",  int'(pif.ex_mc_busy), 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            pif.ex_mc_start = (k == 2);
            pif.ex_mc_len   = (k == 2) ? 6'd9 : 6'd0;
            #1;
            chk("ex_stall", int'(pif.stall), 15);
            chk("ex_busy",  int'(pif.ex_mc_busy), 1);
        end
        tick(); clear_inputs(); #1;
        chk("ex_end_stall", int'(pif.stall), 0);
        chk("ex_end_busy",  int'(pif.ex_mc_busy), 0);
        idle(2);

        // Priority: MEM over EX over ID
        tick(); pif.ex_mc_start = 1'b1; pif.ex_mc_len = 6'd6;
        pif.mem_req = 1'b1; pif.stallreq_id = 1'b1; #1;
        chk("prio_c0", int'(pif.stall), 31);
        tick(); pif.ex_mc_start = 1'b0; pif.ex_mc_len = '0; #1;
        chk("prio_c1", int'(pif.stall), 31);
        tick(); pif.bus_ack = 1'b1; #1;
        chk("prio_c2", int'(pif.stall), 15);
        for (int k = 3; k <= 5; k++) begin
            tick(); pif.mem_req = 1'b0; pif.bus_ack = 1'b0; #1;
            chk("prio_ex", int'(pif.stall), 15);
        end
        tick(); #1;
        chk("prio_id", int'(pif.stall), 7);
        idle(2);

        // Timeout without ack, then ack landing exactly in the timeout cycle
        for (int pass = 0; pass < 2; pass++) begin
            tick(); pif.mem_req = 1'b1; #1;
            for (int k = 1; k < TIMEOUT; k++) begin
                tick(); #1;
                chk("tmo_gnt",  int'(pif.mem_gnt), 1);
                chk("tmo_wait", int'(pif.mem_done), 0);
            end
            tick(); pif.bus_ack = (pass == 1); #1;
            chk("tmo_done",  int'(pif.mem_done), 1);
            chk("tmo_err",   int'(pif.bus_err), (pass == 0) ? 1 : 0);
            chk("tmo_stall", int'(pif.stall), 0);
            tick(); clear_inputs(); #1;
            chk("tmo_idle", int'(pif.mem_gnt), 0);
            idle(1);
        end

        // Asynchronous reset in the middle of a MEM transfer
        tick(); pif.mem_req = 1'b1; #1;
        tick(); #1;
        chk("rstm_gnt",   int'(pif.mem_gnt), 1);
        chk("rstm_stall", int'(pif.stall), 31);
        #1 rst = 1'b0;
        #1;
        chk("rstm_now_stall", int'(pif.stall), 0);
        chk("rstm_now_gnt",   int'(pif.mem_gnt), 0);
        tick(); pif.mem_req = 1'b0;
        tick(); rst = 1'b1; #1;
        chk("rstm_rel_gnt",  int'(pif.mem_gnt), 0);
        chk("rstm_rel_done", int'(pif.mem_done), 0);
        tick(); #1;
        chk("rstm_after_done", int'(pif.mem_done), 0);
        idle(2);

        // Randomized traffic: frequent acks first, then sparse acks to reach timeouts
        for (int i = 0; i < 3000; i++) begin
            tick();
            drive_reqs(1'b1);
            pif.bus_ack     = (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
            pif.ex_mc_start = ($urandom_range(0, 7) == 0);
            pif.ex_mc_len   = CNT_W'($urandom_range(0, 9));
            pif.stallreq_id = ($urandom_range(0, 4) == 0);
        end

        // Drain outstanding requests
        for (int i = 0; i < 8; i++) begin
            tick();
            drive_reqs(1'b0);
            pif.bus_ack     = 1'b1;
            pif.ex_mc_start = 1'b0;
            pif.stallreq_id = 1'b0;
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
